// File: rtl/mioc_pkg.sv
// mioc_pkg: shared DRAM sequencer state encoding and defaults
package mioc_pkg;
  typedef enum logic [2:0] {IDLE, ROW, COL, RFSH, SRFSH, PRECHG} dram_state_t;
  localparam int unsigned MIOC_REFRESH_LIMIT = 64;
endpackage

// File: rtl/mioc_rfsh_timer.sv
// mioc_rfsh_timer: saturating refresh timer, self-refresh row counter and due flag
module mioc_rfsh_timer
  import mioc_pkg::*;
#(
  parameter int unsigned LIMIT = MIOC_REFRESH_LIMIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic       adv,
  output logic [7:0] row,
  output logic       due
);
  localparam logic [7:0] LIM = 8'(LIMIT);
  logic [7:0] tmr;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr <= 8'd0;
      row <= 8'd0;
    end else begin
      tmr <= clr ? 8'd0 : (inc && tmr != LIM) ? tmr + 8'd1 : tmr;
      row <= adv ? row + 8'd1 : row;
    end
  end
  assign due = tmr == LIM;
endmodule

// File: rtl/mioc_dram_ctl.sv
// mioc_dram_ctl: DRAM RAS/MUX/CAS sequencer with RAS-only self-refresh insertion
module mioc_dram_ctl
  import mioc_pkg::*;
#(
  parameter int unsigned REFRESH_LIMIT = MIOC_REFRESH_LIMIT
) (
  input  logic B_PHI,
  input  logic RST_N,
  input  logic BMREQ_N,
  input  logic BRFSH_N,
  input  logic N_BWR,
  input  logic DMA_N,
  input  logic BA15,
  input  logic BA14,
  input  logic BA7,
  input  logic RAM_EN,
  output logic RAS_N,
  output logic MUX,
  output logic CAS1_N,
  output logic CAS2_N,
  output logic RA7,
  output logic SRFSH_ACT
);
  dram_state_t state, nxt;
  logic [7:0] row;
  logic due, cpu_rfsh, unused_ok;
  assign unused_ok = N_BWR;
  assign cpu_rfsh = !BMREQ_N && !BRFSH_N && DMA_N;
  mioc_rfsh_timer #(.LIMIT(REFRESH_LIMIT)) u_tmr (
    .clk  (B_PHI),
    .rst_n(RST_N),
    .clr  (nxt == RFSH || nxt == SRFSH),
    .inc  (state != RFSH && state != SRFSH),
    .adv  (nxt == SRFSH),
    .row  (row),
    .due  (due)
  );
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = cpu_rfsh ? RFSH : (!BMREQ_N && RAM_EN) ? ROW : (due && BMREQ_N) ? SRFSH : IDLE;
      ROW:     nxt = BMREQ_N ? PRECHG : COL;
      COL:     nxt = BMREQ_N ? PRECHG : COL;
      RFSH:    nxt = cpu_rfsh ? RFSH : PRECHG;
      SRFSH:   nxt = PRECHG;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so each strobe changes on the same edge as the state.
  always_ff @(posedge B_PHI) begin
    if (!RST_N) begin
      state     <= IDLE;
      RAS_N     <= 1'b1;
      MUX       <= 1'b0;
      CAS1_N    <= 1'b1;
      CAS2_N    <= 1'b1;
      RA7       <= 1'b0;
      SRFSH_ACT <= 1'b0;
    end else begin
      state     <= nxt;
      RAS_N     <= !(nxt == ROW || nxt == COL || nxt == RFSH || nxt == SRFSH);
      MUX       <= nxt == COL;
      CAS1_N    <= !(nxt == COL && !BA15);
      CAS2_N    <= !(nxt == COL && BA15);
      RA7       <= nxt == COL ? BA14 : nxt == SRFSH ? row[7] : (nxt == ROW || nxt == RFSH) ? BA7 : 1'b0;
      SRFSH_ACT <= nxt == SRFSH;
    end
  end
endmodule

// File: tb/tb_mioc_dram_ctl.sv
// tb_mioc_dram_ctl: directed self-checking bench for the DRAM strobe sequencer
module tb_mioc_dram_ctl;
  logic B_PHI = 1'b0;
  logic RST_N = 1'b0;
  logic BMREQ_N = 1'b1, BRFSH_N = 1'b1, N_BWR = 1'b1, DMA_N = 1'b1;
  logic BA15 = 1'b0, BA14 = 1'b0, BA7 = 1'b0, RAM_EN = 1'b0;
  logic RAS_N, MUX, CAS1_N, CAS2_N, RA7, SRFSH_ACT;
  logic [5:0] o;
  localparam logic [5:0] IDL = 6'b101100;
  int nt = 0;
  int nf = 0;

  assign o = {RAS_N, MUX, CAS1_N, CAS2_N, RA7, SRFSH_ACT};

  always #5 B_PHI = ~B_PHI;

  mioc_dram_ctl #(.REFRESH_LIMIT(64)) dut (
    .B_PHI(B_PHI), .RST_N(RST_N), .BMREQ_N(BMREQ_N), .BRFSH_N(BRFSH_N), .N_BWR(N_BWR),
    .DMA_N(DMA_N), .BA15(BA15), .BA14(BA14), .BA7(BA7), .RAM_EN(RAM_EN),
    .RAS_N(RAS_N), .MUX(MUX), .CAS1_N(CAS1_N), .CAS2_N(CAS2_N), .RA7(RA7), .SRFSH_ACT(SRFSH_ACT)
  );

  task tick;
    @(negedge B_PHI);
  endtask

  task bus_idle;
    BMREQ_N = 1'b1; BRFSH_N = 1'b1; DMA_N = 1'b1; RAM_EN = 1'b0;
    BA15 = 1'b0; BA14 = 1'b0; BA7 = 1'b0; N_BWR = 1'b1;
  endtask

  task do_reset;
    bus_idle();
    RST_N = 1'b0;
    repeat (3) tick();
    RST_N = 1'b1;
  endtask

  task test_reset;
    do_reset();
    nt++; if (o !== IDL) begin nf++; $display("FAIL reset got %b exp %b", o, IDL); end
    BMREQ_N = 1'b0; RAM_EN = 1'b1; BA15 = 1'b1;
    tick(); tick();
    nt++; if (o !== 6'b011000) begin nf++; $display("FAIL rst_pre_col got %b exp %b", o, 6'b011000); end
    RST_N = 1'b0;
    tick();
    nt++; if (o !== IDL) begin nf++; $display("FAIL rst_mid got %b exp %b", o, IDL); end
    RST_N = 1'b1;
    tick();
    nt++; if (o !== 6'b001100) begin nf++; $display("FAIL rst_resume_row got %b exp %b", o, 6'b001100); end
    bus_idle();
    tick(); tick();
  endtask

  task test_lower_read;
    do_reset();
    BMREQ_N = 1'b0; RAM_EN = 1'b1; BA15 = 1'b0; BA7 = 1'b1; BA14 = 1'b0;
    tick();
    nt++; if (o !== 6'b001110) begin nf++; $display("FAIL lb_row got %b exp %b", o, 6'b001110); end
    tick();
    nt++; if (o !== 6'b010100) begin nf++; $display("FAIL lb_col got %b exp %b", o, 6'b010100); end
    tick();
    nt++; if (o !== 6'b010100) begin nf++; $display("FAIL lb_col_hold got %b exp %b", o, 6'b010100); end
    BMREQ_N = 1'b1;
    tick();
    nt++; if (o !== IDL) begin nf++; $display("FAIL lb_prechg got %b exp %b", o, IDL); end
    BMREQ_N = 1'b0;
    tick();
    nt++; if (o !== IDL) begin nf++; $display("FAIL b2b_gap got %b exp %b", o, IDL); end
    tick();
    nt++; if (o !== 6'b001110) begin nf++; $display("FAIL b2b_row got %b exp %b", o, 6'b001110); end
    bus_idle();
    tick();
    nt++; if (o !== IDL) begin nf++; $display("FAIL b2b_abort got %b exp %b", o, IDL); end
    tick();
  endtask

  task test_upper_access;
    do_reset();
    BMREQ_N = 1'b0; RAM_EN = 1'b1; BA15 = 1'b1; BA14 = 1'b1; BA7 = 1'b0;
    tick();
    nt++; if (o !== 6'b001100) begin nf++; $display("FAIL ub_row got %b exp %b", o, 6'b001100); end
    tick();
    nt++; if (o !== 6'b011010) begin nf++; $display("FAIL ub_col got %b exp %b", o, 6'b011010); end
    BMREQ_N = 1'b1;
    tick();
    nt++; if (o !== IDL) begin nf++; $display("FAIL ub_prechg got %b exp %b", o, IDL); end
    bus_idle();
    tick();
  endtask

  task test_cpu_refresh;
    int bad;
    int hits;
    do_reset();
    BMREQ_N = 1'b0; RAM_EN = 1'b0;
    bad = 0;
    repeat (70) begin
      tick();
      if (o !== IDL) bad++;
    end
    nt++; if (bad !== 0) begin nf++; $display("FAIL ramen0_strobes got %0d exp 0", bad); end
    BRFSH_N = 1'b0; DMA_N = 1'b1; RAM_EN = 1'b1; BA7 = 1'b1;
    tick();
    nt++; if (o !== 6'b001110) begin nf++; $display("FAIL rfsh_enter got %b exp %b", o, 6'b001110); end
    tick();
    nt++; if (o !== 6'b001110) begin nf++; $display("FAIL rfsh_hold got %b exp %b", o, 6'b001110); end
    bus_idle();
    tick();
    nt++; if (o !== IDL) begin nf++; $display("FAIL rfsh_prechg got %b exp %b", o, IDL); end
    hits = 0;
    repeat (64) begin
      tick();
      if (SRFSH_ACT !== 1'b0) hits++;
    end
    nt++; if (hits !== 0) begin nf++; $display("FAIL rfsh_timer_clr got %0d srfsh exp 0", hits); end
    tick();
    nt++; if (o !== 6'b001101) begin nf++; $display("FAIL rfsh_then_srfsh got %b exp %b", o, 6'b001101); end
    tick();
    nt++; if (o !== IDL) begin nf++; $display("FAIL srfsh_prechg got %b exp %b", o, IDL); end
  endtask

  task test_dma_starvation;
    int k;
    int last;
    int gap;
    logic [7:0] r;
    logic [5:0] e;
    do_reset();
    DMA_N = 1'b0;
    k = 0;
    last = 0;
    for (int c = 1; c <= 8600; c++) begin
      BRFSH_N = c[0];
      tick();
      if (SRFSH_ACT === 1'b1) begin
        k++;
        gap = (k == 1) ? 65 : 66;
        r = 8'(k - 1);
        e = {5'b00110, 1'b1} | {4'b0000, r[7], 1'b0};
        nt++; if (c - last !== gap) begin nf++; $display("FAIL srfsh_period #%0d got %0d exp %0d", k, c - last, gap); end
        nt++; if (o !== e) begin nf++; $display("FAIL srfsh_out #%0d got %b exp %b", k, o, e); end
        last = c;
      end
    end
    nt++; if (k !== 130) begin nf++; $display("FAIL srfsh_count got %0d exp 130", k); end
    bus_idle();
  endtask

  task test_abort_disable;
    int bad;
    do_reset();
    BMREQ_N = 1'b0; RAM_EN = 1'b1; BA7 = 1'b0; BA15 = 1'b0;
    tick();
    nt++; if (o !== 6'b001100) begin nf++; $display("FAIL abort_row got %b exp %b", o, 6'b001100); end
    BMREQ_N = 1'b1;
    tick();
    nt++; if (o !== IDL) begin nf++; $display("FAIL abort_prechg got %b exp %b", o, IDL); end
    tick();
    nt++; if (o !== IDL) begin nf++; $display("FAIL abort_idle got %b exp %b", o, IDL); end
    BMREQ_N = 1'b0; RAM_EN = 1'b0;
    bad = 0;
    repeat (5) begin
      tick();
      if (o !== IDL) bad++;
    end
    nt++; if (bad !== 0) begin nf++; $display("FAIL disable_strobes got %0d exp 0", bad); end
    DMA_N = 1'b0; BRFSH_N = 1'b0;
    bad = 0;
    repeat (3) begin
      tick();
      if (o !== IDL) bad++;
    end
    nt++; if (bad !== 0) begin nf++; $display("FAIL dma_rfsh_ignored got %0d exp 0", bad); end
    bus_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_lower_read();
    test_upper_access();
    test_cpu_refresh();
    test_abort_disable();
    test_dma_starvation();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule
